// File: rtl/uart_tx_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_serializer_pkg
//  Purpose  : Shared definitions for the UART transmit path. Holds the
//             serializer state encoding and the default frame geometry
//             shared with txfifo and the RX path.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_tx_serializer_pkg;

  // Default geometry shared with txfifo and the receiver.
  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  // Serializer state encoding; any other 3-bit code is illegal.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage : uart_tx_serializer_pkg
`default_nettype wire

// File: rtl/uart_tx_serializer_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_serializer_baud_gen
//  Purpose  : Baud divider. Counts 0..CLKS_PER_BIT-1 and flags the last
//             cycle of every serial bit.
//  Ports    : clk   - system clock
//             rst   - asynchronous, active-low reset
//             clear - hold the count at zero (frame not yet started)
//             tick  - high during the final cycle of a bit period
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer_baud_gen
  import uart_tx_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int             CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Terminal count returns to zero, so the counter never wraps past TERM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == TERM)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = !clear && (cnt_q == TERM);

endmodule : uart_tx_serializer_baud_gen
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_serializer
//  Purpose  : UART transmit serializer fed directly by txfifo. Emits a
//             start bit, DATA_WIDTH data bits LSB first, an optional parity
//             bit and STOP_BITS stop bits, each CLKS_PER_BIT clocks long.
//  Ports    : clk          - system clock
//             rst          - asynchronous, active-low reset
//             data_in      - byte to send (txfifo data_out)
//             data_valid   - data_in valid (txfifo data_valid)
//             transmitting - high for the whole frame; txfifo pops on its rise
//             tx           - serial line, idle high
//             tx_done      - one-cycle pulse after the last stop bit
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  transmitting,
  output logic                  tx,
  output logic                  tx_done
);

  localparam int               BIT_W     = $clog2(DATA_WIDTH) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BIT_W-1:0]      bit_idx_q;
  logic                  stop_cnt_q;
  logic                  parity_q;
  logic                  tx_q;
  logic                  transmitting_q;
  logic                  tx_done_q;

  logic w_baud_clear;
  logic w_baud_tick;

  // Holding the divider cleared while idle means the START bit always
  // begins with a fresh count on the edge that accepts the byte.
  assign w_baud_clear = (state_q == ST_IDLE);

  uart_tx_serializer_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (w_baud_clear),
    .tick  (w_baud_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      shift_q        <= '0;
      bit_idx_q      <= '0;
      stop_cnt_q     <= 1'b0;
      parity_q       <= 1'b0;
      tx_q           <= 1'b1;
      transmitting_q <= 1'b0;
      tx_done_q      <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q           <= 1'b1;
          transmitting_q <= 1'b0;
          bit_idx_q      <= '0;
          stop_cnt_q     <= 1'b0;
          if (data_valid) begin
            shift_q        <= data_in;
            parity_q       <= (^data_in) ^ PAR_ODD;
            state_q        <= ST_START;
            tx_q           <= 1'b0;
            transmitting_q <= 1'b1;
          end
        end
        ST_START: begin
          if (w_baud_tick) begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (w_baud_tick) begin
            if (bit_idx_q == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                state_q <= ST_PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              // tx is registered, so present the next bit while shifting.
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_baud_tick) begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (w_baud_tick) begin
            if (stop_cnt_q == LAST_STOP) begin
              state_q        <= ST_IDLE;
              transmitting_q <= 1'b0;
              tx_done_q      <= 1'b1;
              stop_cnt_q     <= 1'b0;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q        <= ST_IDLE;
          tx_q           <= 1'b1;
          transmitting_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx           = tx_q;
  assign transmitting = transmitting_q;
  assign tx_done      = tx_done_q;

endmodule : uart_tx_serializer
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_serializer
//  Purpose  : Self-checking bench. Three serializer configurations share one
//             stimulus stream: 8N1, 8E1 and 8O2. A frame-level model predicts
//             tx/transmitting/tx_done for every cycle of each instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int ND  = 3;
  localparam int REC = 160;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic [ND-1:0] tx_w, tr_w, dn_w;

  uart_tx_serializer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(N), .PARITY_EN(0),
                       .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .transmitting(tr_w[0]), .tx(tx_w[0]), .tx_done(dn_w[0]));

  uart_tx_serializer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(N), .PARITY_EN(1),
                       .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .transmitting(tr_w[1]), .tx(tx_w[1]), .tx_done(dn_w[1]));

  uart_tx_serializer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(N), .PARITY_EN(1),
                       .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .transmitting(tr_w[2]), .tx(tx_w[2]), .tx_done(dn_w[2]));

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int pen_of(int d);  return (d == 0) ? 0 : 1; endfunction
  function automatic int podd_of(int d); return (d == 2) ? 1 : 0; endfunction
  function automatic int sb_of(int d);   return (d == 2) ? 2 : 1; endfunction

  task automatic check(input string name, input int d, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d) at %0t: actual %0d, expected %0d", name, d, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame model: pos = cycles since the accepting edge (-1 when idle). A frame
  // is a list of line levels, one per bit; tx during cycle pos is
  // bits[pos / N], transmitting spans the frame and tx_done follows it.
  // ---------------------------------------------------------------------------
  int   pos  [ND];
  int   tot  [ND];
  logic fbits[ND][16];

  task automatic model_start(input int d, input logic [DW-1:0] b);
    int nb;
    fbits[d][0] = 1'b0;
    for (int i = 0; i < DW; i++) fbits[d][1 + i] = b[i];
    nb = 1 + DW;
    if (pen_of(d) != 0) begin
      fbits[d][nb] = (^b) ^ logic'(podd_of(d));
      nb++;
    end
    for (int s = 0; s < sb_of(d); s++) fbits[d][nb + s] = 1'b1;
    tot[d] = N * (nb + sb_of(d));
    pos[d] = 0;
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin pos[d] = -1; tot[d] = 1; end
    forever begin
      @(posedge clk);
      for (int d = 0; d < ND; d++) begin
        if (!rst)                                   pos[d] = -1;
        else if (pos[d] >= 0 && pos[d] < tot[d] - 1) pos[d] = pos[d] + 1;
        else if (pos[d] == tot[d] - 1)              pos[d] = tot[d];
        else if (data_valid)                        model_start(d, data_in);
        else                                        pos[d] = -1;
      end
      #2;
      for (int d = 0; d < ND; d++) begin
        int etx, etr, edn;
        if (pos[d] < 0)            begin etx = 1; etr = 0; edn = 0; end
        else if (pos[d] == tot[d]) begin etx = 1; etr = 0; edn = 1; end
        else begin etx = int'(fbits[d][pos[d] / N]); etr = 1; edn = 0; end
        check("tx",           d, int'(tx_w[d]), etx);
        check("transmitting", d, int'(tr_w[d]), etr);
        check("tx_done",      d, int'(dn_w[d]), edn);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Trace capture for the hand-computed expectations.
  // ---------------------------------------------------------------------------
  logic rec_tx[ND][REC];
  logic rec_tr[ND][REC];
  logic rec_dn[ND][REC];

  task automatic sample(input int k);
    for (int d = 0; d < ND; d++) begin
      rec_tx[d][k] = tx_w[d];
      rec_tr[d][k] = tr_w[d];
      rec_dn[d][k] = dn_w[d];
    end
  endtask

  // One-cycle data_valid pulse; sample 0 is the first cycle of the frame.
  task automatic send_and_record(input logic [DW-1:0] b, input logic [DW-1:0] b_after,
                                 input int ncyc);
    @(negedge clk);
    data_in    = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    data_in    = b_after;
    sample(0);
    for (int k = 1; k < ncyc; k++) begin
      @(negedge clk);
      sample(k);
    end
  endtask

  function automatic int count_tr(input int d, input int ncyc);
    int c = 0;
    for (int k = 0; k < ncyc; k++) if (rec_tr[d][k]) c++;
    return c;
  endfunction

  function automatic int count_dn(input int d, input int ncyc);
    int c = 0;
    for (int k = 0; k < ncyc; k++) if (rec_dn[d][k]) c++;
    return c;
  endfunction

  // Data bits sampled one cycle into each bit period, after the start bit.
  function automatic int decode(input int d);
    int v = 0;
    for (int i = 0; i < DW; i++) if (rec_tx[d][N * (i + 1) + 1]) v |= (1 << i);
    return v;
  endfunction

  int exp_a5[10];

  initial begin
    exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    // Reset while data_valid is high.
    rst        = 1'b0;
    data_valid = 1'b1;
    data_in    = 8'hA5;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("reset_tx",   d, int'(tx_w[d]), 1);
      check("reset_tr",   d, int'(tr_w[d]), 0);
      check("reset_done", d, int'(dn_w[d]), 0);
    end
    rst        = 1'b1;
    data_valid = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5 on 8N1.
    send_and_record(8'hA5, 8'h00, 60);
    for (int i = 0; i < 10; i++) check("a5_line", 0, int'(rec_tx[0][N * i + 1]), exp_a5[i]);
    check("a5_tr_cycles",  0, count_tr(0, 60), 40);
    check("a5_done_pos",   0, int'(rec_dn[0][40]), 1);
    check("a5_done_count", 0, count_dn(0, 60), 1);

    // 0x07: even parity bit 1, odd parity bit 0; frame lengths.
    send_and_record(8'h07, 8'h00, 60);
    check("par_even",  1, int'(rec_tx[1][N * 9 + 1]), 1);
    check("par_odd",   2, int'(rec_tx[2][N * 9 + 1]), 0);
    check("len_8n1",   0, count_tr(0, 60), 40);
    check("len_8e1",   1, count_tr(1, 60), 44);
    check("len_8o2",   2, count_tr(2, 60), 48);
    check("done_8o2",  2, int'(rec_dn[2][48]), 1);

    // Back-to-back with data_valid held: exactly one idle cycle between frames.
    @(negedge clk);
    data_valid = 1'b1;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      data_in = DW'($urandom);
      sample(k);
    end
    data_valid = 1'b0;
    begin
      int gap = -1;
      for (int k = 1; k < 140 && gap < 0; k++) begin
        if (rec_tr[0][k - 1] && !rec_tr[0][k]) begin
          gap = 0;
          for (int j = k; j < 150 && !rec_tr[0][j]; j++) gap++;
        end
      end
      check("b2b_gap", 0, gap, 1);
    end
    repeat (60) @(negedge clk);

    // Reset during data bit 3 of 0xFF.
    @(negedge clk);
    data_in    = 8'hFF;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("pre_abort_tr", 0, int'(tr_w[0]), 1);
    rst = 1'b0;
    #1;
    check("abort_tx", 0, int'(tx_w[0]), 1);
    check("abort_tr", 0, int'(tr_w[0]), 0);
    check("abort_dn", 0, int'(dn_w[0]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      sample(k);
    end
    check("abort_no_done", 0, count_dn(0, 30), 0);
    send_and_record(8'h3C, 8'h00, 60);
    check("post_abort_byte", 0, decode(0), 32'h3C);
    check("post_abort_len",  0, count_tr(0, 60), 40);

    // data_in changes mid-frame; the latched byte must go out unchanged.
    send_and_record(8'h55, 8'hAA, 60);
    check("midchg_8n1", 0, decode(0), 32'h55);
    check("midchg_8e1", 1, decode(1), 32'h55);
    send_and_record(8'hAA, 8'h00, 60);
    check("second_byte", 0, decode(0), 32'hAA);

    // Random traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      data_valid = ($urandom_range(0, 3) == 0);
      data_in    = DW'($urandom);
      rst        = ($urandom_range(0, 299) != 0);
    end
    rst        = 1'b1;
    data_valid = 1'b0;
    repeat (60) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_tx_serializer
`default_nettype wire
